// File: rtl/processore_pkg.sv
// Shared opcodes, state/ALU encodings and fetch helpers for processore.
// PROCESSORE_IO_EN enables the IN/OUT opcodes (30/31).
package processore_pkg;

  localparam logic [23:0] RESET_IP = 24'hFF0000;

  localparam logic [7:0] OP_HLT    = 8'h00;
  localparam logic [7:0] OP_NOP    = 8'h01;
  localparam logic [7:0] OP_MVI_AL = 8'h10;
  localparam logic [7:0] OP_MVI_AH = 8'h11;
  localparam logic [7:0] OP_LD     = 8'h20;
  localparam logic [7:0] OP_ST     = 8'h21;
  localparam logic [7:0] OP_IN     = 8'h30;
  localparam logic [7:0] OP_OUT    = 8'h31;
  localparam logic [7:0] OP_ADD    = 8'h40;
  localparam logic [7:0] OP_SUB    = 8'h41;
  localparam logic [7:0] OP_AND    = 8'h42;
  localparam logic [7:0] OP_OR     = 8'h43;
  localparam logic [7:0] OP_NOT    = 8'h44;
  localparam logic [7:0] OP_CMP    = 8'h45;
  localparam logic [7:0] OP_JMP    = 8'h50;
  localparam logic [7:0] OP_JZ     = 8'h51;
  localparam logic [7:0] OP_JNZ    = 8'h52;
  localparam logic [7:0] OP_JC     = 8'h53;

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_OPND,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WR,
    S_IO_RD,
    S_IO_WR,
    S_HALTED,
    S_INVALID
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOT
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic z;
    logic s;
    logic v;
  } flags_t;

  // Operand bytes that follow an opcode; invalid opcodes have none.
  function automatic logic [1:0] opnd_len(input logic [7:0] op);
    case (op)
      OP_MVI_AL, OP_MVI_AH: opnd_len = 2'd1;
      OP_LD, OP_ST,
      OP_JMP, OP_JZ,
      OP_JNZ, OP_JC:        opnd_len = 2'd3;
`ifdef PROCESSORE_IO_EN
      OP_IN, OP_OUT:        opnd_len = 2'd2;
`endif
      default:              opnd_len = 2'd0;
    endcase
  endfunction

  function automatic alu_op_e alu_sel(input logic [7:0] op);
    case (op)
      OP_SUB, OP_CMP: alu_sel = ALU_SUB;
      OP_AND:         alu_sel = ALU_AND;
      OP_OR:          alu_sel = ALU_OR;
      OP_NOT:         alu_sel = ALU_NOT;
      default:        alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/processore_alu.sv
// Combinational 8-bit ALU: result plus C/Z/S/V flags.
// a_i is AL, b_i is AH; SUB computes AL - AH with C as borrow.
module processore_alu
  import processore_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  alu_op_e    op_i,
  output logic [7:0] res_o,
  output flags_t     flags_o
);

  logic [8:0] sum;

  always_comb begin
    sum     = '0;
    res_o   = '0;
    flags_o = '0;
    unique case (op_i)
      ALU_ADD: begin
        sum       = {1'b0, a_i} + {1'b0, b_i};
        res_o     = sum[7:0];
        flags_o.c = sum[8];
        flags_o.v = (a_i[7] == b_i[7]) &&
                    (res_o[7] != a_i[7]);
      end
      ALU_SUB: begin
        sum       = {1'b0, a_i} - {1'b0, b_i};
        res_o     = sum[7:0];
        flags_o.c = sum[8];
        flags_o.v = (a_i[7] != b_i[7]) &&
                    (res_o[7] != a_i[7]);
      end
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_NOT: res_o = ~a_i;
      default: res_o = '0;
    endcase
    flags_o.z = (res_o == 8'h00);
    flags_o.s = res_o[7];
  end

endmodule

// File: rtl/processore.sv
// Multicycle 8-bit CPU with 24-bit address bus and 2-cycle bus accesses.
// PROCESSORE_IO_EN enables IN/OUT on ior_/iow_; otherwise both tie high.
module processore
  import processore_pkg::*;
(
  input  logic        clock,
  input  logic        reset_,
  inout  wire  [7:0]  d7_d0,
  output logic [23:0] a23_a0,
  output logic        mr_,
  output logic        mw_,
  output logic        ior_,
  output logic        iow_,
  output logic        tb_halt,
  output logic        tb_nvi
);

  state_e      state_q, state_d;
  logic        ph_q, ph_d;
  logic        run_q;
  logic [23:0] ip_q, ip_d;
  logic [7:0]  al_q, al_d;
  logic [7:0]  ah_q, ah_d;
  flags_t      f_q, f_d;
  logic [7:0]  op_q, op_d;
  logic [23:0] opnd_q, opnd_d;
  logic [1:0]  idx_q, idx_d;

  alu_op_e     alu_op;
  logic [7:0]  alu_res;
  flags_t      alu_f;
  logic        drv;

  assign alu_op = alu_sel(op_q);

  processore_alu u_alu (
    .a_i     (al_q),
    .b_i     (ah_q),
    .op_i    (alu_op),
    .res_o   (alu_res),
    .flags_o (alu_f)
  );

  // run_q holds the bus idle for the reset cycle; fetch begins next edge.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_FETCH;
      ph_q    <= 1'b0;
      run_q   <= 1'b0;
      ip_q    <= RESET_IP;
      al_q    <= '0;
      ah_q    <= '0;
      f_q     <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      run_q   <= 1'b1;
      ip_q    <= ip_d;
      al_q    <= al_d;
      ah_q    <= ah_d;
      f_q     <= f_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    ip_d    = ip_q;
    al_d    = al_q;
    ah_d    = ah_q;
    f_d     = f_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    idx_d   = idx_q;
    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          ph_d = ~ph_q;
          if (ph_q) begin
            op_d    = d7_d0;
            ip_d    = ip_q + 24'd1;
            opnd_d  = '0;
            idx_d   = '0;
            state_d = (opnd_len(d7_d0) != 2'd0)
                    ? S_FETCH_OPND : S_EXEC;
          end
        end
        S_FETCH_OPND: begin
          ph_d = ~ph_q;
          if (ph_q) begin
            opnd_d[{idx_q, 3'b000} +: 8] = d7_d0;
            ip_d  = ip_q + 24'd1;
            idx_d = idx_q + 2'd1;
            if (idx_q + 2'd1 == opnd_len(op_q))
              state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          state_d = S_FETCH;
          case (op_q)
            OP_HLT:    state_d = S_HALTED;
            OP_NOP:    state_d = S_FETCH;
            OP_MVI_AL: al_d = opnd_q[7:0];
            OP_MVI_AH: ah_d = opnd_q[7:0];
            OP_LD:     state_d = S_MEM_RD;
            OP_ST:     state_d = S_MEM_WR;
`ifdef PROCESSORE_IO_EN
            OP_IN:     state_d = S_IO_RD;
            OP_OUT:    state_d = S_IO_WR;
`endif
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_NOT: begin
              al_d = alu_res;
              f_d  = alu_f;
            end
            OP_CMP:    f_d = alu_f;
            OP_JMP:    ip_d = opnd_q;
            OP_JZ:     if (f_q.z) ip_d = opnd_q;
            OP_JNZ:    if (!f_q.z) ip_d = opnd_q;
            OP_JC:     if (f_q.c) ip_d = opnd_q;
            default:   state_d = S_INVALID;
          endcase
        end
        S_MEM_RD, S_IO_RD: begin
          ph_d = ~ph_q;
          if (ph_q) begin
            al_d    = d7_d0;
            state_d = S_FETCH;
          end
        end
        S_MEM_WR, S_IO_WR: begin
          ph_d = ~ph_q;
          if (ph_q) state_d = S_FETCH;
        end
        S_HALTED, S_INVALID: state_d = state_q;
        default: state_d = S_INVALID;
      endcase
    end
  end

  // Strobe low only in the first cycle of each access.
  always_comb begin
    mr_    = 1'b1;
    mw_    = 1'b1;
    a23_a0 = '0;
`ifdef PROCESSORE_IO_EN
    ior_   = 1'b1;
    iow_   = 1'b1;
`endif
    if (run_q) begin
      unique case (state_q)
        S_FETCH, S_FETCH_OPND: begin
          a23_a0 = ip_q;
          mr_    = ph_q;
        end
        S_MEM_RD: begin
          a23_a0 = opnd_q;
          mr_    = ph_q;
        end
        S_MEM_WR: begin
          a23_a0 = opnd_q;
          mw_    = ph_q;
        end
`ifdef PROCESSORE_IO_EN
        S_IO_RD: begin
          a23_a0 = {8'h00, opnd_q[15:0]};
          ior_   = ph_q;
        end
        S_IO_WR: begin
          a23_a0 = {8'h00, opnd_q[15:0]};
          iow_   = ph_q;
        end
`endif
        default: a23_a0 = '0;
      endcase
    end
  end

`ifndef PROCESSORE_IO_EN
  assign ior_ = 1'b1;
  assign iow_ = 1'b1;
`endif

  assign drv = run_q &&
               (state_q == S_MEM_WR ||
                state_q == S_IO_WR);
  assign d7_d0 = drv ? al_q : 8'hzz;

  assign tb_halt = (state_q == S_HALTED);
  assign tb_nvi  = (state_q == S_INVALID);

endmodule

// File: tb/tb_processore.sv
// Scoreboard bench for processore: bus writes/IO reads are queued
// as expectations and checked by a negedge monitor; end state via run().
module tb_processore;

  logic        clock;
  logic        reset_;
  wire  [7:0]  d7_d0;
  logic [23:0] a23_a0;
  logic        mr_, mw_, ior_, iow_;
  logic        tb_halt, tb_nvi;

  processore dut (
    .clock   (clock),
    .reset_  (reset_),
    .d7_d0   (d7_d0),
    .a23_a0  (a23_a0),
    .mr_     (mr_),
    .mw_     (mw_),
    .ior_    (ior_),
    .iow_    (iow_),
    .tb_halt (tb_halt),
    .tb_nvi  (tb_nvi)
  );

  typedef struct packed {
    logic [1:0]  k;
    logic [23:0] a;
    logic [7:0]  d;
  } ev_t;

  logic [7:0] mem [logic [23:0]];
  logic [7:0] iom [logic [15:0]];
  ev_t        exp_q[$];
  int         checks;
  int         errors;
  logic       drv_en;
  logic [7:0] drv;

  assign d7_d0 = drv_en ? drv : 8'hzz;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] rdmem(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  function automatic logic [7:0] rdio(input logic [15:0] a);
    return iom.exists(a) ? iom[a] : 8'h00;
  endfunction

  task automatic poke(input logic [23:0] a, input logic [255:0] v,
                      input int n);
    for (int i = 0; i < n; i++)
      mem[a + 24'(i)] = v[8*(n-1-i) +: 8];
  endtask

  task automatic push(input logic [1:0] k, input logic [23:0] a,
                      input logic [7:0] d);
    ev_t e;
    e.k = k;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Memory/device answer in the second cycle of a read.
  always @(posedge clock) begin
    if (!mr_) begin
      drv    <= rdmem(a23_a0);
      drv_en <= 1'b1;
    end else if (!ior_) begin
      drv    <= rdio(a23_a0[15:0]);
      drv_en <= 1'b1;
    end else begin
      drv_en <= 1'b0;
    end
  end

  logic        follow;
  logic        fw;
  logic [23:0] fa;
  logic [7:0]  fd;

  always @(negedge clock) begin
    logic [3:0] lo;
    ev_t e;
    lo = ~{mr_, mw_, ior_, iow_};
    if (!reset_) begin
      follow = 1'b0;
    end else begin
      if (follow) begin
        chk("cyc2_strobes", 32'({mr_, mw_, ior_, iow_}), 32'hF);
        if (fw) begin
          chk("cyc2_addr", 32'(a23_a0), 32'(fa));
          chk("cyc2_data", 32'(d7_d0), 32'(fd));
        end
        follow = 1'b0;
      end else if (lo != 4'h0) begin
        chk("one_strobe", 32'($countones(lo)), 32'd1);
        follow = 1'b1;
        fw     = !mw_ || !iow_;
        fa     = a23_a0;
        fd     = d7_d0;
        if (!mw_ || !iow_ || !ior_) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: addr %0h data %0h",
                     a23_a0, d7_d0);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind", 32'({!mw_, !iow_, !ior_}),
                32'(e.k == 2'd0 ? 3'b100 :
                    e.k == 2'd1 ? 3'b010 : 3'b001));
            chk("ev_addr", 32'(a23_a0), 32'(e.a));
            if (e.k != 2'd2) chk("ev_data", 32'(d7_d0), 32'(e.d));
          end
          if (!mw_) mem[a23_a0] = d7_d0;
        end
      end
    end
  end

  task automatic run(input string nm, input bit exp_halt,
                     input logic [7:0] exp_al, input logic [3:0] exp_f,
                     input int exp_cyc);
    int cyc;
    bit done;
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    chk({nm, "/rst_strobes"}, 32'({mr_, mw_, ior_, iow_}), 32'hF);
    chk({nm, "/rst_addr"}, 32'(a23_a0), 32'h0);
    chk({nm, "/rst_status"}, 32'({tb_halt, tb_nvi}), 32'h0);
    reset_ = 1'b1;
    @(negedge clock);
    chk({nm, "/first_fetch"}, 32'({mr_, a23_a0}), 32'h00FF0000);
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      done = tb_halt || tb_nvi;
    end
    chk({nm, "/finished"}, 32'(done), 32'd1);
    chk({nm, "/status"}, 32'({tb_halt, tb_nvi}),
        exp_halt ? 32'h2 : 32'h1);
    if (exp_cyc != 0) chk({nm, "/cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "/al"}, 32'(dut.al_q), 32'(exp_al));
    chk({nm, "/flags_czsv"}, 32'(dut.f_q), 32'(exp_f));
    repeat (3) begin
      @(negedge clock);
      chk({nm, "/idle"}, 32'({mr_, mw_, ior_, iow_, tb_halt, tb_nvi}),
          exp_halt ? 32'h3E : 32'h3D);
    end
    chk({nm, "/pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_ = 1'b0;
    drv_en = 1'b0;
    follow = 1'b0;

    mem.delete();
    poke(24'hFF0000, 256'h00, 1);
    run("hlt", 1'b1, 8'h00, 4'b0000, 4);

    mem.delete();
    poke(24'hFF0000,
         256'h10_05_11_FB_40_21_00_01_00_53_20_00_FF_00, 14);
    poke(24'hFF0020, 256'h51_30_00_FF_00, 5);
    poke(24'hFF0030, 256'h10_AA_21_02_01_00_00, 7);
    push(2'd0, 24'h000100, 8'h00);
    push(2'd0, 24'h000102, 8'hAA);
    run("add_carry", 1'b1, 8'hAA, 4'b1100, 0);

    mem.delete();
    poke(24'hFF0000, 256'h10_7F_11_01_40_21_00_02_00_00, 10);
    push(2'd0, 24'h000200, 8'h80);
    run("add_ovf", 1'b1, 8'h80, 4'b0011, 0);

    mem.delete();
    poke(24'hFF0000,
         256'h10_A5_21_34_12_00_10_00_20_34_12_00_00, 13);
    push(2'd0, 24'h001234, 8'hA5);
    run("st_ld", 1'b1, 8'hA5, 4'b0000, 0);

    mem.delete();
    poke(24'hFF0000,
         256'h10_10_11_20_41_21_00_03_00_45_53_40_00_FF_42_43_44,
         17);
    poke(24'hFF0011,
         256'h21_01_03_00_11_DF_45_51_50_00_FF_FF_FF, 13);
    poke(24'hFF0040, 256'hFF, 1);
    poke(24'hFF0050, 256'h00, 1);
    push(2'd0, 24'h000300, 8'hF0);
    push(2'd0, 24'h000301, 8'hDF);
    run("logic_cmp", 1'b1, 8'hDF, 4'b0100, 0);

    mem.delete();
    poke(24'hFF0000, 256'h50_FF_FF_FF, 4);
    poke(24'hFFFFFF, 256'h10_80_11_01_41_00, 6);
    run("ip_wrap_sub", 1'b1, 8'h7F, 4'b0001, 0);

    mem.delete();
    poke(24'hFF0000, 256'hFF, 1);
    run("invalid", 1'b0, 8'h00, 4'b0000, 4);

    mem.delete();
    iom.delete();
    iom[16'h0080] = 8'h3C;
    poke(24'hFF0000, 256'h30_80_00_31_00_03_52_10_00_FF_FF, 11);
    poke(24'hFF0010, 256'h00, 1);
`ifdef PROCESSORE_IO_EN
    push(2'd2, 24'h000080, 8'h00);
    push(2'd1, 24'h000300, 8'h3C);
    run("io", 1'b1, 8'h3C, 4'b0000, 0);
`else
    run("io_off", 1'b0, 8'h00, 4'b0000, 4);
`endif

    begin
      bit seen;
      mem.delete();
      poke(24'hFF0000, 256'h10_A5_21_34_12_00_00, 7);
      push(2'd0, 24'h001234, 8'hA5);
      reset_ = 1'b0;
      repeat (2) @(negedge clock);
      reset_ = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clock);
        seen = !mw_;
      end
      chk("midrst/write_seen", 32'(seen), 32'd1);
      #1 reset_ = 1'b0;
      #1;
      chk("midrst/strobes", 32'({mr_, mw_, ior_, iow_}), 32'hF);
      chk("midrst/addr", 32'(a23_a0), 32'h0);
      chk("midrst/status", 32'({tb_halt, tb_nvi}), 32'h0);
      exp_q.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/processore.md
PROCESSORE -- requirements
Module: processore

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have: reset_  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: d7_d0  inout  8  data bus; driven only during write cycles, else high-Z.
REQ-004 SHALL have: a23_a0  out  24  address bus; memory uses all 24 bits, I/O uses a23_a0[15:0] with upper bits 0.
REQ-005 SHALL have: mr_, mw_, ior_, iow_  out  1 each  active-low memory read/write and I/O read/write strobes.
REQ-006 SHALL have: tb_halt  out  1  high after HLT executes; tb_nvi  out  1  high after an invalid opcode is fetched.

Function
REQ-007 Registers SHALL be AL, AH (8 b), IP (24 b) and F (C, Z, S, V).
REQ-008 Every bus read SHALL take 2 cycles: cycle 1 address valid, strobe low; cycle 2 strobe high, d7_d0 sampled on that cycle's closing rising edge.
REQ-009 Every bus write SHALL take 2 cycles: address and data driven both cycles, strobe low in cycle 1 only.
REQ-010 At most one strobe SHALL be low at any time; all strobes SHALL be high between accesses.
REQ-011 Fetch SHALL read the opcode at IP, then each operand byte, incrementing IP modulo 2^24 after each byte; multibyte operands are little-endian.
REQ-012 Opcodes SHALL be: 00 HLT; 01 NOP; 10 MOV $imm8,AL; 11 MOV $imm8,AH; 20 MOV addr24,AL (load); 21 MOV AL,addr24 (store); 30 IN port16,AL; 31 OUT AL,port16.
REQ-013 Further opcodes SHALL be: 40 ADD AH,AL; 41 SUB AH,AL; 42 AND AH,AL; 43 OR AH,AL; 44 NOT AL; 45 CMP AH,AL (SUB without writing AL).
REQ-014 Jump opcodes SHALL be: 50 JMP addr24; 51 JZ; 52 JNZ; 53 JC; each taken jump sets IP to addr24, else IP continues.
REQ-015 ALU results SHALL be 8 bit with F updated: Z = result zero, S = bit 7, C = carry out (ADD) or borrow (SUB/CMP), V = signed overflow; AND/OR/NOT clear C and V.
REQ-016 MOV and jump instructions SHALL leave F unchanged.
REQ-017 The state machine SHALL have states FETCH, FETCH_OPND, EXEC, MEM_RD, MEM_WR, IO_RD, IO_WR, HALTED, INVALID.
REQ-018 HLT SHALL enter HALTED: tb_halt = 1, bus idle, remain until reset.
REQ-019 Any unlisted opcode SHALL enter INVALID: tb_nvi = 1 one cycle after the opcode read completes, bus idle, remain until reset.
REQ-020 tb_halt and tb_nvi SHALL never both be 1.

Reset
REQ-021 While reset_ = 0: IP = 24'hFF0000, F = 0, AL = AH = 0, state FETCH, all strobes 1, d7_d0 high-Z, a23_a0 = 0, tb_halt = tb_nvi = 0.
REQ-022 Reset asserted mid-access SHALL immediately deassert strobes and release d7_d0.
REQ-023 The first fetch SHALL start on the first rising edge after reset_ rises.

Configuration
REQ-024 Macro PROCESSORE_IO_EN defined: opcodes 30/31 execute per REQ-012 and use ior_/iow_.
REQ-025 Macro PROCESSORE_IO_EN undefined: opcodes 30/31 are invalid (REQ-019), and ior_/iow_ are tied high.

Structure
REQ-026 A package processore_pkg SHALL hold the opcode constants, state enum, ALU-op enum and reset IP constant.
REQ-027 A single sub-module processore_alu SHALL implement the combinational ALU and flag generation.

Verification
REQ-028 Memory at FF0000 = 00 -> tb_halt rises after one 2-cycle fetch plus one cycle, no write strobes.
REQ-029 FF0000: 10 05 11 FB 40 00 -> AL = 00, C = 1, Z = 1, S = 0, V = 0, then halt.
REQ-030 FF0000: 10 7F 11 01 40 00 -> AL = 80, S = 1, V = 1, C = 0.
REQ-031 FF0000: 10 A5 21 34 12 00 00 -> mw_ low one cycle, a23_a0 = 001234, d7_d0 = A5; then 20 34 12 00 reloads AL = A5.
REQ-032 FF0000: FF -> tb_nvi = 1, tb_halt = 0, strobes high thereafter; with IO disabled, opcode 30 gives the same result.
REQ-033 IO enabled: 30 80 00 with device returning 3C -> ior_ low one cycle at a23_a0 = 000080, AL = 3C; JNZ to FF0010 holding 00 -> halt.
